// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between the I-cache miss path
// and the D-cache miss/writeback path. A winning request is latched, driven to
// pmem until pmem_resp, then answered with a one-cycle resp and line data.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   icache_read / icache_address    I-side line read request (level) and address
//   icache_rdata / icache_resp      I-side returned line and completion pulse
//   dcache_read / dcache_write      D-side read / writeback requests (level)
//   dcache_address / dcache_wdata   D-side line address and writeback data
//   dcache_rdata / dcache_resp      D-side returned line and completion pulse
//   pmem_read / pmem_write          memory strobes
//   pmem_address / pmem_wdata       memory address and write data
//   pmem_rdata / pmem_resp          memory read data and completion pulse
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int FAIR       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

    state_t                r_state;
    logic                  r_last_d;      // last grant went to the D side
    logic                  r_op_write;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic                  r_icache_resp;
    logic                  r_dcache_resp;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] r_icache_rdata;
    logic [LINE_WIDTH-1:0] r_dcache_rdata;

    logic w_req_i;
    logic w_req_d;
    logic w_prefer_d;
    logic w_grant_i;
    logic w_grant_d;

    always_comb begin
        w_req_i    = icache_read;
        w_req_d    = dcache_read | dcache_write;
        // Tie-break: alternate away from the previous winner when fair,
        // otherwise the D side always wins.
        w_prefer_d = (FAIR != 0) ? ~r_last_d : 1'b1;
        w_grant_d  = w_req_d & (~w_req_i | w_prefer_d);
        w_grant_i  = w_req_i & ~w_grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_last_d       <= 1'b0;
            r_op_write     <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_icache_resp  <= 1'b0;
            r_dcache_resp  <= 1'b0;
            r_address      <= '0;
            r_wdata        <= '0;
            r_icache_rdata <= '0;
            r_dcache_rdata <= '0;
        end else begin
            r_icache_resp <= 1'b0;
            r_dcache_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                    if (w_grant_d) begin
                        // read+write together is treated as a writeback
                        r_state      <= BUSY_D;
                        r_last_d     <= 1'b1;
                        r_address    <= dcache_address;
                        r_wdata      <= dcache_wdata;
                        r_op_write   <= dcache_write;
                        r_pmem_read  <= ~dcache_write;
                        r_pmem_write <= dcache_write;
                    end else if (w_grant_i) begin
                        r_state      <= BUSY_I;
                        r_last_d     <= 1'b0;
                        r_address    <= icache_address;
                        r_op_write   <= 1'b0;
                        r_pmem_read  <= 1'b1;
                    end
                end
                BUSY_I: begin
                    if (pmem_resp) begin
                        r_icache_rdata <= pmem_rdata;
                        r_icache_resp  <= 1'b1;
                        r_pmem_read    <= 1'b0;
                        r_pmem_write   <= 1'b0;
                        r_state        <= RELEASE;
                    end
                end
                BUSY_D: begin
                    if (pmem_resp) begin
                        if (!r_op_write) begin
                            r_dcache_rdata <= pmem_rdata;
                        end
                        r_dcache_resp <= 1'b1;
                        r_pmem_read   <= 1'b0;
                        r_pmem_write  <= 1'b0;
                        r_state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign icache_rdata = r_icache_rdata;
    assign icache_resp  = r_icache_resp;
    assign dcache_rdata = r_dcache_rdata;
    assign dcache_resp  = r_dcache_resp;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_address;
    assign pmem_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: vector table, directed multi-cycle sequences,
// a FAIR=0 instance, and a randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          icache_read, dcache_read, dcache_write, pmem_resp;
    logic [AW-1:0] icache_address, dcache_address, pmem_address;
    logic [LW-1:0] icache_rdata, dcache_rdata, dcache_wdata, pmem_wdata, pmem_rdata;
    logic          icache_resp, dcache_resp, pmem_read, pmem_write;

    logic          f0_icache_read, f0_dcache_read, f0_dcache_write, f0_pmem_resp;
    logic [AW-1:0] f0_icache_address, f0_dcache_address, f0_pmem_address;
    logic [LW-1:0] f0_icache_rdata, f0_dcache_rdata, f0_dcache_wdata, f0_pmem_wdata, f0_pmem_rdata;
    logic          f0_icache_resp, f0_dcache_resp, f0_pmem_read, f0_pmem_write;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FAIR(1)) u_dut (
        .clk(clk), .reset(reset),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FAIR(0)) u_dut_f0 (
        .clk(clk), .reset(reset),
        .icache_read(f0_icache_read), .icache_address(f0_icache_address),
        .icache_rdata(f0_icache_rdata), .icache_resp(f0_icache_resp),
        .dcache_read(f0_dcache_read), .dcache_write(f0_dcache_write),
        .dcache_address(f0_dcache_address), .dcache_wdata(f0_dcache_wdata),
        .dcache_rdata(f0_dcache_rdata), .dcache_resp(f0_dcache_resp),
        .pmem_read(f0_pmem_read), .pmem_write(f0_pmem_write),
        .pmem_address(f0_pmem_address), .pmem_wdata(f0_pmem_wdata),
        .pmem_rdata(f0_pmem_rdata), .pmem_resp(f0_pmem_resp)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        icache_read  = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        pmem_resp    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        logic i_rd;
        logic d_rd;
        logic d_wr;
        logic exp_rd;
        logic exp_wr;
        int   side;     // 0 none, 1 I, 2 D
    } vec_t;

    vec_t vt[8];

    // randomized-phase state
    logic          req_i_act, req_d_act, req_d_wr;
    logic [AW-1:0] req_i_addr, req_d_addr;
    logic [LW-1:0] req_d_wdata;
    int            cur_side, last_side, mem_wait, edge_no, free_edge, pick;
    logic [AW-1:0] cur_addr;
    logic          cur_wr;
    logic [LW-1:0] cur_wdata;
    logic [LW-1:0] mem [16];
    logic          e_rd, e_wr, e_iresp, e_dresp;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata, e_irdata, e_drdata;

    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd, rd, rd2, last_drd;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        icache_address = '0; dcache_address = '0; dcache_wdata = '0; pmem_rdata = '0;
        f0_icache_read = 1'b0; f0_dcache_read = 1'b0; f0_dcache_write = 1'b0; f0_pmem_resp = 1'b0;
        f0_icache_address = '0; f0_dcache_address = '0; f0_dcache_wdata = '0; f0_pmem_rdata = '0;

        //                 i_rd  d_rd  d_wr  exp_rd exp_wr side
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2};  // tie after reset: D
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};  // tie again: I
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};  // I only
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2};  // D read only
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2};  // D write only
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1};  // tie, last D: I
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2};  // tie, rd+wr is a write
        vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};  // nothing pending

        do_reset();
        chk("reset pmem_read", pmem_read, 1'b0);
        chk("reset pmem_write", pmem_write, 1'b0);
        chk("reset icache_resp", icache_resp, 1'b0);
        chk("reset dcache_resp", dcache_resp, 1'b0);
        chk("reset icache_rdata", icache_rdata, '0);
        chk("reset dcache_rdata", dcache_rdata, '0);
        chk("reset pmem_address", pmem_address, '0);
        chk("reset pmem_wdata", pmem_wdata, '0);
        last_drd = '0;

        // ---------------- vector table ----------------
        for (int k = 0; k < 8; k++) begin
            ia = AW'(16'h0100 + k * 16);
            da = AW'(16'h0200 + k * 16);
            wd = rnd_line();
            rd = rnd_line();
            icache_address = ia; dcache_address = da; dcache_wdata = wd;
            icache_read = vt[k].i_rd; dcache_read = vt[k].d_rd; dcache_write = vt[k].d_wr;
            @(negedge clk);
            chk($sformatf("vec%0d pmem_read", k), pmem_read, vt[k].exp_rd);
            chk($sformatf("vec%0d pmem_write", k), pmem_write, vt[k].exp_wr);
            if (vt[k].side != 0) begin
                chk($sformatf("vec%0d pmem_address", k), pmem_address, (vt[k].side == 1) ? ia : da);
                if (vt[k].exp_wr) chk($sformatf("vec%0d pmem_wdata", k), pmem_wdata, wd);
                pmem_rdata = rd; pmem_resp = 1'b1;
                @(negedge clk);
                pmem_resp = 1'b0;
                chk($sformatf("vec%0d icache_resp", k), icache_resp, vt[k].side == 1);
                chk($sformatf("vec%0d dcache_resp", k), dcache_resp, vt[k].side == 2);
                if (vt[k].side == 1) chk($sformatf("vec%0d icache_rdata", k), icache_rdata, rd);
                else if (vt[k].exp_rd) last_drd = rd;
                if (vt[k].side == 2) chk($sformatf("vec%0d dcache_rdata", k), dcache_rdata, last_drd);
                idle_inputs();
                @(negedge clk);
            end else begin
                idle_inputs();
            end
        end

        // ---------------- I-only read, 3-cycle memory ----------------
        icache_address = 16'h0040; icache_read = 1'b1;
        @(negedge clk);
        chk("iread pmem_read", pmem_read, 1'b1);
        chk("iread pmem_address", pmem_address, 16'h0040);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("iread pmem_read held", pmem_read, 1'b1);
            chk("iread icache_resp early", icache_resp, 1'b0);
        end
        pmem_rdata = {16{8'hA5}}; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("iread icache_resp", icache_resp, 1'b1);
        chk("iread icache_rdata", icache_rdata, {16{8'hA5}});
        chk("iread dcache_resp", dcache_resp, 1'b0);
        chk("iread pmem_read release", pmem_read, 1'b0);
        icache_read = 1'b0;
        @(negedge clk);
        chk("iread resp single pulse", icache_resp, 1'b0);

        // ---------------- D write held stable ----------------
        dcache_address = 16'h1230; dcache_wdata = 128'h0123456789ABCDEF0123456789ABCDEF; dcache_write = 1'b1;
        @(negedge clk);
        dcache_wdata = rnd_line();
        for (int c = 0; c < 3; c++) begin
            chk("dwr pmem_write", pmem_write, 1'b1);
            chk("dwr pmem_read", pmem_read, 1'b0);
            chk("dwr pmem_address", pmem_address, 16'h1230);
            chk("dwr pmem_wdata", pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
            @(negedge clk);
        end
        pmem_rdata = rnd_line(); pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("dwr dcache_resp", dcache_resp, 1'b1);
        chk("dwr icache_resp", icache_resp, 1'b0);
        chk("dwr dcache_rdata unchanged", dcache_rdata, last_drd);
        dcache_write = 1'b0;
        @(negedge clk);

        // ---------------- address change mid-grant ----------------
        dcache_address = 16'h2000; dcache_read = 1'b1;
        @(negedge clk);
        dcache_address = 16'h3000;
        for (int c = 0; c < 3; c++) begin
            chk("midgrant pmem_address", pmem_address, 16'h2000);
            chk("midgrant pmem_read", pmem_read, 1'b1);
            @(negedge clk);
        end
        rd = rnd_line(); pmem_rdata = rd; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("midgrant dcache_resp", dcache_resp, 1'b1);
        chk("midgrant dcache_rdata", dcache_rdata, rd);
        dcache_read = 1'b0;
        @(negedge clk);

        // ---------------- reset mid BUSY_I ----------------
        icache_address = 16'h0080; icache_read = 1'b1;
        @(negedge clk);
        chk("rstmid pmem_read before", pmem_read, 1'b1);
        reset = 1'b1; icache_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid pmem_read", pmem_read, 1'b0);
        chk("rstmid pmem_write", pmem_write, 1'b0);
        chk("rstmid icache_resp", icache_resp, 1'b0);
        chk("rstmid dcache_resp", dcache_resp, 1'b0);
        chk("rstmid icache_rdata", icache_rdata, '0);
        chk("rstmid dcache_rdata", dcache_rdata, '0);
        pmem_rdata = rnd_line(); pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("rstmid late icache_resp", icache_resp, 1'b0);
        chk("rstmid late pmem_read", pmem_read, 1'b0);
        @(negedge clk);
        chk("rstmid late icache_resp 2", icache_resp, 1'b0);

        // ---------------- back-to-back I reads ----------------
        icache_address = 16'h0050; icache_read = 1'b1;
        @(negedge clk);
        chk("b2b first pmem_read", pmem_read, 1'b1);
        rd = rnd_line(); pmem_rdata = rd; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("b2b first resp", icache_resp, 1'b1);
        chk("b2b first rdata", icache_rdata, rd);
        chk("b2b release pmem_read", pmem_read, 1'b0);
        icache_read = 1'b0;
        @(negedge clk);
        chk("b2b idle resp", icache_resp, 1'b0);
        chk("b2b idle pmem_read", pmem_read, 1'b0);
        icache_address = 16'h0060; icache_read = 1'b1;
        @(negedge clk);
        chk("b2b second pmem_read", pmem_read, 1'b1);
        chk("b2b second pmem_address", pmem_address, 16'h0060);
        chk("b2b second no early resp", icache_resp, 1'b0);
        rd2 = rnd_line(); pmem_rdata = rd2; pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("b2b second resp", icache_resp, 1'b1);
        chk("b2b second rdata", icache_rdata, rd2);
        icache_read = 1'b0;
        @(negedge clk);
        chk("b2b second single pulse", icache_resp, 1'b0);

        // ---------------- FAIR=0 instance: D always wins ties ----------------
        f0_dcache_address = 16'h0C00; f0_dcache_read = 1'b1;
        @(negedge clk);
        chk("fair0 pre pmem_read", f0_pmem_read, 1'b1);
        f0_pmem_rdata = rnd_line(); f0_pmem_resp = 1'b1;
        @(negedge clk);
        f0_pmem_resp = 1'b0;
        chk("fair0 pre dcache_resp", f0_dcache_resp, 1'b1);
        f0_dcache_read = 1'b0;
        @(negedge clk);
        for (int rep = 0; rep < 2; rep++) begin
            ia = AW'(16'h0A00 + rep * 16);
            da = AW'(16'h0B00 + rep * 16);
            wd = rnd_line();
            f0_icache_address = ia; f0_dcache_address = da; f0_dcache_wdata = wd;
            f0_icache_read = 1'b1; f0_dcache_write = (rep == 0); f0_dcache_read = (rep != 0);
            @(negedge clk);
            chk("fair0 tie d address", f0_pmem_address, da);
            chk("fair0 tie d write", f0_pmem_write, rep == 0);
            chk("fair0 tie d read", f0_pmem_read, rep != 0);
            if (rep == 0) chk("fair0 tie d wdata", f0_pmem_wdata, wd);
            rd = rnd_line(); f0_pmem_rdata = rd; f0_pmem_resp = 1'b1;
            @(negedge clk);
            f0_pmem_resp = 1'b0;
            chk("fair0 tie dcache_resp", f0_dcache_resp, 1'b1);
            chk("fair0 tie icache_resp", f0_icache_resp, 1'b0);
            if (rep == 1) chk("fair0 tie dcache_rdata", f0_dcache_rdata, rd);
            f0_dcache_read = 1'b0; f0_dcache_write = 1'b0;
            @(negedge clk);
            chk("fair0 gap pmem_read", f0_pmem_read, 1'b0);
            @(negedge clk);
            chk("fair0 pending i read", f0_pmem_read, 1'b1);
            chk("fair0 pending i address", f0_pmem_address, ia);
            rd2 = rnd_line(); f0_pmem_rdata = rd2; f0_pmem_resp = 1'b1;
            @(negedge clk);
            f0_pmem_resp = 1'b0;
            chk("fair0 icache_resp", f0_icache_resp, 1'b1);
            chk("fair0 icache_rdata", f0_icache_rdata, rd2);
            f0_icache_read = 1'b0;
            @(negedge clk);
        end

        // ---------------- randomized run vs transaction-level model ----------------
        do_reset();
        for (int m = 0; m < 16; m++) mem[m] = rnd_line();
        req_i_act = 1'b0; req_d_act = 1'b0; req_d_wr = 1'b0;
        req_i_addr = '0; req_d_addr = '0; req_d_wdata = '0;
        cur_side = 0; last_side = 1; mem_wait = 0; edge_no = 0; free_edge = 0;
        cur_addr = '0; cur_wr = 1'b0; cur_wdata = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_iresp = 1'b0; e_dresp = 1'b0;
        e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            chk("rnd pmem_read", pmem_read, e_rd);
            chk("rnd pmem_write", pmem_write, e_wr);
            if (e_rd || e_wr) chk("rnd pmem_address", pmem_address, e_addr);
            if (e_wr) chk("rnd pmem_wdata", pmem_wdata, e_wdata);
            chk("rnd icache_resp", icache_resp, e_iresp);
            chk("rnd dcache_resp", dcache_resp, e_dresp);
            chk("rnd icache_rdata", icache_rdata, e_irdata);
            chk("rnd dcache_rdata", dcache_rdata, e_drdata);

            // requesters: drop on resp, otherwise sometimes raise a new request
            if (e_iresp) req_i_act = 1'b0;
            else if (!req_i_act && $urandom_range(0, 2) == 0) begin
                req_i_act  = 1'b1;
                req_i_addr = AW'($urandom_range(0, 15) * 16);
            end
            if (e_dresp) req_d_act = 1'b0;
            else if (!req_d_act && $urandom_range(0, 2) == 0) begin
                req_d_act   = 1'b1;
                req_d_wr    = ($urandom_range(0, 1) == 1);
                req_d_addr  = AW'($urandom_range(0, 15) * 16);
                req_d_wdata = rnd_line();
            end
            icache_read    = req_i_act;
            icache_address = req_i_act ? req_i_addr : AW'($urandom);
            dcache_write   = req_d_act && req_d_wr;
            dcache_read    = req_d_act && (!req_d_wr || ($urandom_range(0, 1) == 1));
            dcache_address = req_d_act ? req_d_addr : AW'($urandom);
            dcache_wdata   = req_d_act ? req_d_wdata : rnd_line();

            // memory: answer the open transaction after a random wait,
            // otherwise occasionally pulse a spurious pmem_resp
            pmem_resp  = 1'b0;
            pmem_rdata = rnd_line();
            if (cur_side != 0) begin
                if (mem_wait == 0) begin
                    pmem_resp = 1'b1;
                    if (!cur_wr) pmem_rdata = mem[cur_addr[7:4]];
                end else begin
                    mem_wait--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                pmem_resp = 1'b1;
            end

            // expectations for the cycle after the coming edge
            e_iresp = 1'b0;
            e_dresp = 1'b0;
            if (cur_side != 0 && pmem_resp) begin
                if (cur_side == 1) begin
                    e_iresp  = 1'b1;
                    e_irdata = pmem_rdata;
                end else begin
                    e_dresp = 1'b1;
                    if (cur_wr) mem[cur_addr[7:4]] = cur_wdata;
                    else e_drdata = pmem_rdata;
                end
                cur_side  = 0;
                e_rd      = 1'b0;
                e_wr      = 1'b0;
                free_edge = edge_no + 2;   // one resp cycle, one idle cycle
            end else if (cur_side == 0 && edge_no >= free_edge && (req_i_act || req_d_act)) begin
                if (req_i_act && req_d_act) pick = (last_side == 1) ? 2 : 1;
                else pick = req_i_act ? 1 : 2;
                last_side = pick;
                cur_side  = pick;
                cur_addr  = (pick == 1) ? req_i_addr : req_d_addr;
                cur_wr    = (pick == 2) && req_d_wr;
                cur_wdata = req_d_wdata;
                mem_wait  = int'($urandom_range(0, 3));
                e_rd      = !cur_wr;
                e_wr      = cur_wr;
                e_addr    = cur_addr;
                e_wdata   = cur_wdata;
            end
            edge_no++;
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
